wave_cfg_ctrl: RTL and testbench
================================

# wave_cfg_ctrl

Configuration and sequencing controller for the 16-channel wave-generator summing tree. It accepts per-channel amplitude, offset and phase-word writes into a shadow register bank, and commits them atomically to the active bank that drives the tree's packed `amps`/`offsets`/`phasewords` buses. It also generates the tree's periodic input strobe and counts returned output strobes.

## Interface
Parameters:
- `RATE_DIV`, default 4: strobe period in `clk` cycles; legal range 2..65535.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write can be accepted; equals `!commit_busy`.
- `wr_chan`  in  4  target channel, 0..15.
- `wr_field`  in  2  field select: 0 = amp, 1 = offset, 2 = phaseword, 3 = illegal.
- `wr_data`  in  16  write data; amp is signed, offset and phaseword are unsigned.
- `commit_req`  in  1  single-cycle pulse requesting shadow→active copy.
- `commit_busy`  out  1  a commit is pending.
- `run`  in  1  level enable for strobe generation.
- `amps`, `offsets`, `phasewords`  out  256 each  active bank; channel n occupies bits [16n+15:16n].
- `gen_active`  out  1  single-cycle strobe to the tree's active input.
- `gen_done`  in  1  the tree's active output.
- `sample_count`  out  16  count of `gen_done` pulses; wraps modulo 2^16.
- `err`  out  1  sticky flag: an illegal write was accepted.

## Operation
- States: IDLE (`run`=0) and RUN (`run`=1). The state register follows `run`, sampled each edge. `commit_busy` is a separate pending flag.
- Write: accepted on an edge where `wr_valid && wr_ready`. Field 0–2 updates the shadow word [`wr_chan`][`wr_field`]. Field 3 leaves all state unchanged and sets `err`. `err` clears only on reset.
- Divider: counts 0..RATE_DIV-1 in RUN and is forced to 0 in IDLE. `gen_active` is registered high for exactly the cycle after the divider reaches RATE_DIV-1.
- Commit in IDLE: the edge that samples `commit_req` copies all 48 shadow words into the active bank. `commit_busy` stays 0.
- Commit in RUN: the edge sampling `commit_req` sets `commit_busy`. The copy occurs on the edge that raises `gen_active`, so the new configuration is on the buses during the strobe cycle. That same edge clears `commit_busy`.
- `commit_req` while `commit_busy`=1: ignored; only one copy occurs.
- Write and `commit_req` on the same edge (`wr_ready`=1): the write is included in the copy.
- `run` falls while `commit_busy`=1: the copy occurs on the first edge in IDLE, and `commit_busy` clears there.
- `sample_count` increments on each edge with `gen_done`=1, independent of state.
- Reset, mid-operation included: all shadow and active words 0, state IDLE, divider 0, `gen_active`=0, `commit_busy`=0, `wr_ready`=1, `sample_count`=0, `err`=0. Any pending commit is discarded.

## Timing
- Write-to-shadow latency: 1 edge. Shadow changes are never visible on the active buses until a commit.
- First `gen_active` is high in cycle RATE_DIV after the edge where `run`=1 is first sampled. Subsequent strobes follow every RATE_DIV cycles.
- IDLE commit: active buses update at the sampling edge (1-cycle latency).
- RUN commit: latency is at most RATE_DIV cycles, measured to the strobe edge.
- `wr_ready` is combinational from `commit_busy`, with no path from `wr_valid`.
- Active bus outputs are registered and change only at commit edges.

## Configuration
- `WAVE_CFG_READBACK_EN` defined:
  - Adds inputs `rd_chan` (4 bits) and `rd_field` (2 bits) and output `rd_data` (16 bits).
  - `rd_data` is a combinational read of the addressed shadow word; `rd_field`=3 returns 0.
- Undefined: these ports and their logic are absent; everything else is unchanged.

## Test plan
- Reset then IDLE write ch5 amp=16'h7FFF, commit → `amps[95:80]`=16'h7FFF on the commit edge; all other bits 0; `commit_busy` never 1.
- RATE_DIV=4, `run`=1: `gen_active` pulses every 4 cycles. Commit one cycle after a strobe → `commit_busy`=1 and `wr_ready`=0 until the next strobe; buses change exactly on that strobe cycle.
- Same-edge write ch0 phaseword=16'h1234 with `commit_req` in IDLE → `phasewords[15:0]`=16'h1234 after that edge.
- Write with `wr_field`=3 → `err`=1 and no shadow/active change. A second `commit_req` while pending → a single copy.
- Drive 65537 `gen_done` pulses → `sample_count`=1. Assert `reset` mid-pending → all outputs return to reset values asynchronously.
- With `WAVE_CFG_READBACK_EN`: write ch15 offset=16'hABCD → `rd_chan`=15, `rd_field`=1 reads 16'hABCD before commit.

Source files
------------

// File: rtl/wave_cfg_ctrl.sv
// wave_cfg_ctrl
//   Configuration and sequencing controller for the 16-channel wave-generator
//   summing tree. Per-channel amp/offset/phaseword writes land in a shadow
//   bank and are copied atomically into the active bank that drives the tree.
//   Also generates the periodic tree input strobe and counts returned strobes.
//
// Parameters
//   RATE_DIV      strobe period in clk cycles (2..65535)
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   wr_valid/wr_ready    shadow write handshake (wr_ready = !commit_busy)
//   wr_chan/field/data   write address (channel, field 0..2, 3 illegal) and data
//   commit_req           shadow -> active copy request pulse
//   commit_busy          a commit is waiting for the next strobe edge
//   run                  level enable for strobe generation
//   amps/offsets/phasewords  active bank, channel n at bits [16n+15:16n]
//   gen_active           single-cycle strobe to the tree
//   gen_done             tree output strobe, counted into sample_count
//   sample_count         gen_done pulse count, wraps modulo 2^16
//   err                  sticky: an illegal-field write was accepted
//
// Optional build macro
//   WAVE_CFG_READBACK_EN adds rd_chan/rd_field inputs and rd_data output, a
//   combinational read of the shadow bank (rd_field 3 reads 0).

module wave_cfg_ctrl #(
   parameter int unsigned RATE_DIV = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_valid,
   output logic         wr_ready,
   input  logic [3:0]   wr_chan,
   input  logic [1:0]   wr_field,
   input  logic [15:0]  wr_data,
   input  logic         commit_req,
   output logic         commit_busy,
   input  logic         run,
   output logic [255:0] amps,
   output logic [255:0] offsets,
   output logic [255:0] phasewords,
   output logic         gen_active,
   input  logic         gen_done,
   output logic [15:0]  sample_count,
`ifdef WAVE_CFG_READBACK_EN
   input  logic [3:0]   rd_chan,
   input  logic [1:0]   rd_field,
   output logic [15:0]  rd_data,
`endif
   output logic         err
);

   localparam logic [15:0] DIV_LAST = 16'(RATE_DIV - 1);

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   div_q, div_d;
   logic          gen_q, gen_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [255:0]  sh_amp_q, sh_amp_d;
   logic [255:0]  sh_off_q, sh_off_d;
   logic [255:0]  sh_ph_q, sh_ph_d;
   logic [255:0]  act_amp_q, act_amp_d;
   logic [255:0]  act_off_q, act_off_d;
   logic [255:0]  act_ph_q, act_ph_d;

   logic          wr_acc;
   logic          strobe_edge;
   logic          commit_any;
   logic          do_copy;
   logic [7:0]    wr_base;

   always_comb begin
      state_d     = run ? ST_RUN : ST_IDLE;

      // strobe_edge marks the edge that raises gen_active
      strobe_edge = (state_q == ST_RUN) && (div_q == DIV_LAST);
      div_d       = '0;
      if ((state_q == ST_RUN) && !strobe_edge) begin
         div_d = div_q + 16'd1;
      end
      gen_d       = strobe_edge;

      wr_acc      = wr_valid && !busy_q;
      wr_base     = {wr_chan, 4'b0000};
      sh_amp_d    = sh_amp_q;
      sh_off_d    = sh_off_q;
      sh_ph_d     = sh_ph_q;
      if (wr_acc) begin
         case (wr_field)
            2'd0:    sh_amp_d[wr_base +: 16] = wr_data;
            2'd1:    sh_off_d[wr_base +: 16] = wr_data;
            2'd2:    sh_ph_d[wr_base +: 16]  = wr_data;
            default: ;
         endcase
      end
      err_d       = err_q | (wr_acc && (wr_field == 2'd3));

      // Copy from the post-write shadow so a same-edge write is included.
      // A pending commit absorbs further requests; in IDLE it fires at once,
      // in RUN it waits for the strobe edge.
      commit_any  = busy_q | commit_req;
      do_copy     = commit_any && ((state_q == ST_IDLE) || strobe_edge);
      busy_d      = commit_any && !do_copy;
      act_amp_d   = do_copy ? sh_amp_d : act_amp_q;
      act_off_d   = do_copy ? sh_off_d : act_off_q;
      act_ph_d    = do_copy ? sh_ph_d  : act_ph_q;

      cnt_d       = gen_done ? cnt_q + 16'd1 : cnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         div_q     <= '0;
         gen_q     <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         sh_amp_q  <= '0;
         sh_off_q  <= '0;
         sh_ph_q   <= '0;
         act_amp_q <= '0;
         act_off_q <= '0;
         act_ph_q  <= '0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         gen_q     <= gen_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         sh_amp_q  <= sh_amp_d;
         sh_off_q  <= sh_off_d;
         sh_ph_q   <= sh_ph_d;
         act_amp_q <= act_amp_d;
         act_off_q <= act_off_d;
         act_ph_q  <= act_ph_d;
      end
   end

   assign wr_ready     = !busy_q;
   assign commit_busy  = busy_q;
   assign gen_active   = gen_q;
   assign sample_count = cnt_q;
   assign err          = err_q;
   assign amps         = act_amp_q;
   assign offsets      = act_off_q;
   assign phasewords   = act_ph_q;

`ifdef WAVE_CFG_READBACK_EN
   logic [7:0] rd_base;

   always_comb begin
      rd_base = {rd_chan, 4'b0000};
      rd_data = '0;
      case (rd_field)
         2'd0:    rd_data = sh_amp_q[rd_base +: 16];
         2'd1:    rd_data = sh_off_q[rd_base +: 16];
         2'd2:    rd_data = sh_ph_q[rd_base +: 16];
         default: rd_data = '0;
      endcase
   end
`endif

endmodule

// File: tb/tb_wave_cfg_ctrl.sv
// tb_wave_cfg_ctrl
//   Scoreboard bench for wave_cfg_ctrl. The driver applies inputs, advances a
//   behavioural model of the controller after each clock edge and queues the
//   expected outputs; a monitor on the falling edge pops and compares.

module tb_wave_cfg_ctrl;

   localparam int unsigned R = 4;

   logic         clk;
   logic         reset;
   logic         wr_valid;
   logic         wr_ready;
   logic [3:0]   wr_chan;
   logic [1:0]   wr_field;
   logic [15:0]  wr_data;
   logic         commit_req;
   logic         commit_busy;
   logic         run;
   logic [255:0] amps;
   logic [255:0] offsets;
   logic [255:0] phasewords;
   logic         gen_active;
   logic         gen_done;
   logic [15:0]  sample_count;
   logic         err;
`ifdef WAVE_CFG_READBACK_EN
   logic [3:0]   rd_chan;
   logic [1:0]   rd_field;
   logic [15:0]  rd_data;
   bit           rd_fix;
`endif

   wave_cfg_ctrl #(.RATE_DIV(R)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_chan      (wr_chan),
      .wr_field     (wr_field),
      .wr_data      (wr_data),
      .commit_req   (commit_req),
      .commit_busy  (commit_busy),
      .run          (run),
      .amps         (amps),
      .offsets      (offsets),
      .phasewords   (phasewords),
      .gen_active   (gen_active),
      .gen_done     (gen_done),
      .sample_count (sample_count),
`ifdef WAVE_CFG_READBACK_EN
      .rd_chan      (rd_chan),
      .rd_field     (rd_field),
      .rd_data      (rd_data),
`endif
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [15:0] m_sh  [16][3];
   logic [15:0] m_act [16][3];
   int          m_t;        // edges since run was first sampled high
   bit          m_in_run;
   bit          m_pend;
   bit          m_err;
   int          m_cnt;
   bit          m_strobe;

   typedef struct {
      logic         gen;
      logic         busy;
      logic [255:0] amps;
      logic [255:0] offs;
      logic [255:0] phs;
      logic [15:0]  cnt;
      logic         err;
      logic [15:0]  rd;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic model_reset();
      for (int unsigned n = 0; n < 16; n++) begin
         for (int unsigned f = 0; f < 3; f++) begin
            m_sh[n][f]  = '0;
            m_act[n][f] = '0;
         end
      end
      m_t      = 0;
      m_in_run = 0;
      m_pend   = 0;
      m_err    = 0;
      m_cnt    = 0;
      m_strobe = 0;
   endtask

   // Strobes land on edges RATE_DIV, 2*RATE_DIV, ... after run is first sampled.
   task automatic model_edge();
      bit k_strobe;
      if (reset) begin
         model_reset();
         return;
      end
      k_strobe = m_in_run && (((m_t + 1) % R) == 0);
      if (wr_valid && !m_pend) begin
         if (wr_field == 2'd3) m_err = 1;
         else m_sh[wr_chan][wr_field] = wr_data;
      end
      if (m_pend || commit_req) begin
         if (!m_in_run || k_strobe) begin
            m_act  = m_sh;
            m_pend = 0;
         end else begin
            m_pend = 1;
         end
      end
      if (gen_done) m_cnt = (m_cnt + 1) % 65536;
      if (run) m_t = m_in_run ? m_t + 1 : 0;
      m_in_run = run;
      m_strobe = k_strobe;
   endtask

   function automatic logic [255:0] pack_act(int unsigned f);
      logic [255:0] v;
      v = '0;
      for (int unsigned n = 0; n < 16; n++) v[n*16 +: 16] = m_act[n][f];
      return v;
   endfunction

   task automatic push_exp();
      exp_t e;
      e.gen  = m_strobe;
      e.busy = m_pend;
      e.amps = pack_act(0);
      e.offs = pack_act(1);
      e.phs  = pack_act(2);
      e.cnt  = 16'(m_cnt);
      e.err  = m_err;
      e.rd   = '0;
`ifdef WAVE_CFG_READBACK_EN
      if (rd_field != 2'd3) e.rd = m_sh[rd_chan][rd_field];
`endif
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
`ifdef WAVE_CFG_READBACK_EN
      if (rd_fix) begin
         rd_chan  = 4'd15;
         rd_field = 2'd1;
      end else begin
         rd_chan  = 4'($urandom_range(15));
         rd_field = 2'($urandom_range(3));
      end
`endif
      push_exp();
   endtask

   task automatic write_once(input logic [3:0] ch, input logic [1:0] f,
                             input logic [15:0] d);
      wr_valid = 1'b1;
      wr_chan  = ch;
      wr_field = f;
      wr_data  = d;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic wait_strobe();
      for (int unsigned i = 0; i < 2 * R; i++) begin
         step();
         if (m_strobe) break;
      end
   endtask

   // ---------------- monitor ----------------
   task automatic chk(input string name, input logic [255:0] act,
                      input logic [255:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gen_active",   256'(gen_active),   256'(e.gen));
            chk("commit_busy",  256'(commit_busy),  256'(e.busy));
            chk("wr_ready",     256'(wr_ready),     256'(!e.busy));
            chk("amps",         amps,               e.amps);
            chk("offsets",      offsets,            e.offs);
            chk("phasewords",   phasewords,         e.phs);
            chk("sample_count", 256'(sample_count), 256'(e.cnt));
            chk("err",          256'(err),          256'(e.err));
`ifdef WAVE_CFG_READBACK_EN
            chk("rd_data",      256'(rd_data),      256'(e.rd));
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset      = 1'b1;
      wr_valid   = 1'b0;
      wr_chan    = '0;
      wr_field   = '0;
      wr_data    = '0;
      commit_req = 1'b0;
      run        = 1'b0;
      gen_done   = 1'b0;
`ifdef WAVE_CFG_READBACK_EN
      rd_fix     = 0;
      rd_chan    = '0;
      rd_field   = '0;
`endif
      model_reset();
      step();
      step();
      reset = 1'b0;
      step();

      // IDLE write then commit: ch5 amp
      write_once(4'd5, 2'd0, 16'h7FFF);
      step();
      commit_req = 1'b1;
      step();
      commit_req = 1'b0;
      step();

      // same-edge write and commit in IDLE
      commit_req = 1'b1;
      write_once(4'd0, 2'd2, 16'h1234);
      commit_req = 1'b0;
      step();

      // illegal field: err set, nothing else changes
      write_once(4'd7, 2'd3, 16'hFFFF);
      commit_req = 1'b1;
      step();
      commit_req = 1'b0;
      step();

      // shadow readback before commit (observable only with readback built in)
`ifdef WAVE_CFG_READBACK_EN
      rd_fix = 1;
`endif
      write_once(4'd15, 2'd1, 16'hABCD);
      step();
      step();
`ifdef WAVE_CFG_READBACK_EN
      rd_fix = 0;
`endif

      // RUN: commit one cycle after a strobe, with a write on the request edge,
      // a second request and a write attempt while pending
      run = 1'b1;
      repeat (3 * R) step();
      wait_strobe();
      commit_req = 1'b1;
      write_once(4'd3, 2'd0, 16'h8001);
      wr_valid = 1'b1;
      wr_chan  = 4'd4;
      wr_field = 2'd1;
      wr_data  = 16'h5555;
      step();
      wr_valid   = 1'b0;
      commit_req = 1'b0;
      repeat (2 * R) step();

      // run falls while a commit is pending
      wait_strobe();
      write_once(4'd9, 2'd2, 16'hBEEF);
      commit_req = 1'b1;
      step();
      commit_req = 1'b0;
      run = 1'b0;
      repeat (3) step();

      // randomized traffic
      for (int unsigned i = 0; i < 3000; i++) begin
         wr_valid   = ($urandom_range(1) == 1);
         wr_chan    = 4'($urandom_range(15));
         wr_field   = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
         wr_data    = 16'($urandom);
         commit_req = ($urandom_range(7) == 0);
         gen_done   = ($urandom_range(2) == 0);
         if ($urandom_range(19) == 0) run = !run;
         step();
      end
      wr_valid   = 1'b0;
      commit_req = 1'b0;
      gen_done   = 1'b0;

      // asynchronous reset while a commit is pending
      run = 1'b1;
      write_once(4'd1, 2'd0, 16'h0F0F);
      repeat (R + 1) step();
      wait_strobe();
      commit_req = 1'b1;
      step();
      commit_req = 1'b0;
      #1;
      reset = 1'b1;
      model_reset();
      void'(exp_q.pop_back());
      push_exp();
      run = 1'b0;
      step();
      reset = 1'b0;
      repeat (2) step();

      // sample_count wrap: 65537 pulses
      gen_done = 1'b1;
      repeat (65537) step();
      gen_done = 1'b0;
      step();

      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
